code_seq_gen: RTL and testbench
===============================

# code_seq_gen

Parametrised binary-phase code sequencer for the HFSWR transmitter. It replaces the single-code generator/mapper pair with one block that holds a writable bank of `N_CODES` code words. On each sync pulse it plays one code word MSB-first as a bipolar baseband signal `±amplitude`. It can cycle through the bank on successive pulses (complementary-pair / multi-code transmission) and reports busy and done status to the pulse controller.

## Interface
Parameters:
- `NB_REG`, 32, width of code words and of the `numdig`/`tb` registers.
- `NB_OUTPUT`, 16, width of the signed output sample.
- `N_CODES`, 4, bank depth; must be a power of 2, ≥2.
- `NB_IDX`, `$clog2(N_CODES)`, bank index width.

Ports:
- `i_clk` in 1: system clock. One clock domain.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_sinc` in 1: one-cycle start pulse.
- `i_wr_en` in 1: bank write strobe.
- `i_wr_addr` in `NB_IDX`: bank write index.
- `i_wr_data` in `NB_REG`: code word to write.
- `i_numdig` in `NB_REG`: digits per code, 0..`NB_REG`.
- `i_tb` in `NB_REG`: clock cycles per digit.
- `i_amp` in `NB_OUTPUT`: unsigned output magnitude.
- `i_mode` in 1: 0 = fixed index, 1 = cycle through the bank.
- `i_sel` in `NB_IDX`: index used when `i_mode`=0.
- `o_signal` out `NB_OUTPUT`: signed two's-complement sample.
- `o_busy` out 1: high while a code is playing.
- `o_done` out 1: one-cycle pulse at the end of each sequence.
- `o_code_idx` out `NB_IDX`: index of the last started code.

## Operation
- Bank: `N_CODES`×`NB_REG` registers, written when `i_wr_en` is high. All entries are 0 after reset.
  - A write during a run never affects the code being played, because the word is copied at start.
- States: IDLE and RUN.
- IDLE → RUN on `i_sinc` with an effective `numdig` ≥1. On that edge the block latches:
  - the code word from index `idx`;
  - effective `numdig` = min(`i_numdig`, `NB_REG`);
  - effective `tb` = max(`i_tb`, 1);
  - the clamped amplitude;
  - `idx` into `o_code_idx`.
- Index selection:
  - `i_mode`=0: `idx` = `i_sel`.
  - `i_mode`=1: `idx` = internal pointer, which then increments modulo `N_CODES`.
  - The pointer resets to 0 and is unchanged by starts in mode 0.
- Digit order: bit `numdig`-1 of the word first, down to bit 0. Bits at or above `numdig` are ignored.
- Output mapping:
  - digit 1 → `+A`; digit 0 → `−A`, where `A` = min(`i_amp`, 2^(`NB_OUTPUT`−1)−1).
  - Negation is `NB_OUTPUT`-bit two's complement. It never overflows because of the clamp.
  - `o_signal` = 0 in IDLE.
- RUN: a digit counter and a `tb` counter advance each cycle. After the last digit's `tb` cycles the block returns to IDLE and pulses `o_done`.
- A sync pulse with effective `numdig`=0:
  - stays in IDLE and pulses `o_done` on the next cycle;
  - does not advance the pointer or update `o_code_idx`;
  - `o_signal` stays 0.
- A sync pulse while in RUN is ignored (see Configuration).
- Register inputs (`i_numdig`, `i_tb`, `i_amp`, `i_mode`, `i_sel`) have no effect once RUN has started.
- Reset during RUN: on the reset edge, return to IDLE with all outputs at reset values and the bank cleared. There is no done pulse.

## Timing
- Reset values: `o_signal`=0, `o_busy`=0, `o_done`=0, `o_code_idx`=0, pointer=0.
- `i_sinc` sampled high at edge `t`:
  - `o_busy`=1 and `o_signal` = digit 0 in cycle `t`+1.
  - Digit `k` occupies cycles `t`+1+`k`·`tb` … `t`+(`k`+1)·`tb`.
- After the last digit, in cycle `t`+`numdig`·`tb`+1: `o_signal`=0, `o_busy`=0, `o_done`=1 for exactly one cycle.
- A sync pulse that lands in the `o_done` cycle (`o_busy`=0) is accepted. The next sequence's first digit appears the following cycle, giving back-to-back codes with a single zero cycle between them.
- `i_wr_en` and `i_sinc` in the same cycle, writing the selected index: the start latches the old bank contents. The write lands on the same edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `CODE_SEQ_RETRIGGER_EN` defined:
  - `i_sinc` during RUN aborts the current code and restarts on that edge with freshly latched inputs and the next index, exactly as from IDLE.
  - No `o_done` pulse is issued for the aborted sequence.
- `CODE_SEQ_RETRIGGER_EN` undefined: `i_sinc` in RUN is ignored.

## Test plan
- **Barker-13:** bank[0]=0x00001F35, `numdig`=13, `tb`=4, `amp`=0x4000, mode 0, sel 0, pulse → 52 cycles of `o_signal` pattern 1111100110101 (each digit 4 cycles, 0x4000 / 0xC000), then `o_done` at cycle 53, `o_busy` high for cycles 1–52.
- **Cycle mode:** bank[0..3] distinct, mode 1, four pulses spaced 100 cycles, `numdig`=8, `tb`=2 → `o_code_idx` 0,1,2,3; a fifth pulse wraps to 0.
- **Clamping:** `numdig`=40 → 32 digits played; `tb`=0 → 1 cycle/digit; `amp`=0x8000 → output ±0x7FFF; `numdig`=0 → `o_done` at `t`+1, `o_busy` never set, pointer unchanged.
- **Mid-run interference:**
  - change `i_numdig` and write the active bank entry during RUN → current sequence unchanged;
  - with retrigger off, a second pulse is ignored;
  - with `CODE_SEQ_RETRIGGER_EN`, the sequence restarts at `t`+1 with no done pulse.
- **Reset mid-run:** assert `i_rst` at digit 5 → next cycle all outputs 0, bank reads back 0, no `o_done`.
- **Back-to-back:** pulse in the `o_done` cycle → new first digit appears the next cycle.

Source files
------------

// File: rtl/code_seq_gen.sv
// Binary-phase code sequencer: bank of N_CODES code words, plays one word per sync pulse as +/-amplitude.
// Optional CODE_SEQ_RETRIGGER_EN: a sync pulse during a run restarts playback instead of being ignored.
module code_seq_gen #(
  parameter int NB_REG    = 32,
  parameter int NB_OUTPUT = 16,
  parameter int N_CODES   = 4,
  parameter int NB_IDX    = $clog2(N_CODES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sinc,
  input  logic                 i_wr_en,
  input  logic [NB_IDX-1:0]    i_wr_addr,
  input  logic [NB_REG-1:0]    i_wr_data,
  input  logic [NB_REG-1:0]    i_numdig,
  input  logic [NB_REG-1:0]    i_tb,
  input  logic [NB_OUTPUT-1:0] i_amp,
  input  logic                 i_mode,
  input  logic [NB_IDX-1:0]    i_sel,
  output logic [NB_OUTPUT-1:0] o_signal,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NB_IDX-1:0]    o_code_idx
);

  localparam int NB_CNT = $clog2(NB_REG + 1);
  localparam logic [NB_OUTPUT-1:0] AMP_MAX = {1'b0, {(NB_OUTPUT-1){1'b1}}};
`ifdef CODE_SEQ_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;

  logic [NB_REG-1:0]    bank [N_CODES];
  logic [NB_IDX-1:0]    ptr, idx;
  logic [NB_REG-1:0]    sh, sh_start;
  logic [NB_CNT-1:0]    ndig_eff, dig_left;
  logic [NB_REG-1:0]    tb_eff, tb_r, tb_left;
  logic [NB_OUTPUT-1:0] amp_eff, amp_r;
  logic                 accept, start, zero_start, last;

  function automatic logic [NB_OUTPUT-1:0] map_dig(input logic d, input logic [NB_OUTPUT-1:0] a);
    return d ? a : ('0 - a);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    ndig_eff   = (i_numdig > NB_REG) ? NB_CNT'(NB_REG) : i_numdig[NB_CNT-1:0];
    tb_eff     = (i_tb == '0) ? NB_REG'(1) : i_tb;
    amp_eff    = (i_amp > AMP_MAX) ? AMP_MAX : i_amp;
    idx        = i_mode ? ptr : i_sel;
    // left-align the active digits so the current digit is always the MSB
    sh_start   = bank[idx] << (NB_CNT'(NB_REG) - ndig_eff);
    last       = (tb_left == '0) && (dig_left == '0);
    accept     = i_sinc && ((state == IDLE) || RETRIG);
    start      = accept && (ndig_eff != '0);
    zero_start = accept && (ndig_eff == '0);
    state_n    = state;
    if (start)                       state_n = RUN;
    else if (zero_start)             state_n = IDLE;
    else if (state == RUN && last)   state_n = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_CODES; i++) bank[i] <= '0;
      ptr        <= '0;
      sh         <= '0;
      dig_left   <= '0;
      tb_r       <= '0;
      tb_left    <= '0;
      amp_r      <= '0;
      o_signal   <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_code_idx <= '0;
    end else begin
      // bank read for a same-cycle start sees the old word; the write lands on this edge
      if (i_wr_en) bank[i_wr_addr] <= i_wr_data;
      o_done <= 1'b0;
      if (start) begin
        sh         <= sh_start;
        dig_left   <= ndig_eff - NB_CNT'(1);
        tb_r       <= tb_eff;
        tb_left    <= tb_eff - NB_REG'(1);
        amp_r      <= amp_eff;
        o_code_idx <= idx;
        if (i_mode) ptr <= ptr + NB_IDX'(1);
        o_busy     <= 1'b1;
        o_signal   <= map_dig(sh_start[NB_REG-1], amp_eff);
      end else if (zero_start) begin
        o_done   <= 1'b1;
        o_busy   <= 1'b0;
        o_signal <= '0;
      end else if (state == RUN) begin
        if (tb_left != '0) begin
          tb_left <= tb_left - NB_REG'(1);
        end else if (dig_left != '0) begin
          dig_left <= dig_left - NB_CNT'(1);
          tb_left  <= tb_r - NB_REG'(1);
          sh       <= sh << 1;
          o_signal <= map_dig(sh[NB_REG-2], amp_r);
        end else begin
          o_busy   <= 1'b0;
          o_signal <= '0;
          o_done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_code_seq_gen.sv
// Directed self-checking bench for code_seq_gen; expected samples derived from hand-written code words.
module tb_code_seq_gen;

  logic        clk = 1'b0;
  logic        rst, sinc, wr_en, mode;
  logic [1:0]  wr_addr, sel;
  logic [31:0] wr_data, numdig, tbv;
  logic [15:0] amp;
  logic [15:0] signal;
  logic        busy, done;
  logic [1:0]  code_idx;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] cw [4] = '{8'hA5, 8'h3C, 8'hF0, 8'h01};

  code_seq_gen dut (
    .i_clk(clk), .i_rst(rst), .i_sinc(sinc), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_numdig(numdig), .i_tb(tbv), .i_amp(amp), .i_mode(mode),
    .i_sel(sel), .o_signal(signal), .o_busy(busy), .o_done(done), .o_code_idx(code_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse();
    sinc = 1'b1;
    @(negedge clk);
    sinc = 1'b0;
  endtask

  // called in cycle t+1; returns in the done cycle
  task automatic play_digits(input string tag, input logic [31:0] w, input int n, input int tb,
                             input logic [15:0] a);
    logic [15:0] e;
    for (int k = 0; k < n; k++)
      for (int j = 0; j < tb; j++) begin
        e = w[n-1-k] ? a : 16'h0 - a;
        chk({tag, "_sig"}, signal, e);
        chk({tag, "_busy"}, busy, 1);
        @(negedge clk);
      end
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_dbusy"}, busy, 0);
    chk({tag, "_dsig"}, signal, 0);
  endtask

  initial begin
    rst = 1'b1; sinc = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    numdig = '0; tbv = '0; amp = '0; mode = 1'b0; sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_sig", signal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", code_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    // Barker-13
    wr(2'd0, 32'h0000_1F35);
    numdig = 13; tbv = 4; amp = 16'h4000; mode = 1'b0; sel = 2'd0;
    pulse();
    play_digits("barker", 32'h1F35, 13, 4, 16'h4000);
    check_done("barker");
    chk("barker_idx", code_idx, 0);
    @(negedge clk);
    chk("barker_done1", done, 0);

    // cycle mode through the bank, fifth pulse wraps
    for (int i = 0; i < 4; i++) wr(2'(i), {24'h0, cw[i]});
    mode = 1'b1; numdig = 8; tbv = 2;
    for (int i = 0; i < 5; i++) begin
      pulse();
      chk("cyc_idx", code_idx, i % 4);
      chk("cyc_sig0", signal, cw[i%4][7] ? 16'h4000 : 16'hC000);
      repeat (99) @(negedge clk);
    end

    // clamping: 40 -> 32 digits, tb 0 -> 1, amp 0x8000 -> 0x7FFF
    wr(2'd2, 32'h8000_0001);
    mode = 1'b0; sel = 2'd2; numdig = 40; tbv = 0; amp = 16'h8000;
    pulse();
    play_digits("clamp", 32'h8000_0001, 32, 1, 16'h7FFF);
    check_done("clamp");
    @(negedge clk);

    // zero digits in cycle mode: done only, no pointer/idx change
    mode = 1'b1; numdig = 0; tbv = 2; amp = 16'h4000;
    pulse();
    check_done("zero");
    chk("zero_idx", code_idx, 2);
    @(negedge clk);
    chk("zero_done1", done, 0);
    chk("zero_busy1", busy, 0);
    numdig = 8;
    pulse();
    chk("zero_ptr", code_idx, 1);
    play_digits("zero_nxt", 32'h3C, 8, 2, 16'h4000);
    check_done("zero_nxt");
    @(negedge clk);

    // mid-run interference: inputs, bank write, (ignored) second sync
    mode = 1'b0; sel = 2'd3; numdig = 8; tbv = 2; amp = 16'h0100;
    pulse();
    fork
      play_digits("intf", 32'h01, 8, 2, 16'h0100);
      begin
        repeat (3) @(negedge clk);
        numdig = 3; amp = 16'h0005; tbv = 7;
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'hFF;
`ifndef CODE_SEQ_RETRIGGER_EN
        sinc = 1'b1;
`endif
        @(negedge clk);
        wr_en = 1'b0; sinc = 1'b0;
      end
    join
    check_done("intf");
    @(negedge clk);

`ifdef CODE_SEQ_RETRIGGER_EN
    // retrigger restarts on the sync edge with fresh inputs
    sel = 2'd0; numdig = 8; tbv = 2; amp = 16'h0100;
    pulse();
    repeat (3) @(negedge clk);
    numdig = 4; tbv = 1; sel = 2'd1;
    pulse();
    chk("retrig_idx", code_idx, 1);
    play_digits("retrig", 32'h3C, 4, 1, 16'h0100);
    check_done("retrig");
    @(negedge clk);
`endif

    // write and sync on the same edge: old word is played
    mode = 1'b0; sel = 2'd1; numdig = 8; tbv = 1; amp = 16'h0100;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'hC3; sinc = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; sinc = 1'b0;
    play_digits("wrsync", 32'h3C, 8, 1, 16'h0100);
    check_done("wrsync");
    @(negedge clk);

    // back-to-back: sync in the done cycle
    pulse();
    play_digits("b2b_a", 32'hC3, 8, 1, 16'h0100);
    check_done("b2b_a");
    sel = 2'd3;
    pulse();
    play_digits("b2b_b", 32'hFF, 8, 1, 16'h0100);
    check_done("b2b_b");
    @(negedge clk);

    // reset mid-run at digit 5
    sel = 2'd0; numdig = 8; tbv = 4; amp = 16'h4000;
    pulse();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_sig", signal, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_idx", code_idx, 0);
    @(negedge clk);
    chk("mrst_done1", done, 0);
    numdig = 4; tbv = 1; amp = 16'h0010;
    pulse();
    play_digits("mrst_bank", 32'h0, 4, 1, 16'h0010);
    check_done("mrst_bank");
    @(negedge clk);
    mode = 1'b1; sel = 2'd3;
    pulse();
    chk("mrst_ptr0", code_idx, 0);
    repeat (8) @(negedge clk);
    pulse();
    chk("mrst_ptr1", code_idx, 1);
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
